line_sink: RTL and testbench
============================

Name: line_sink

Overview:
- Receiving end of the box generator pixel-write interface (wr / delta_x / pix / done).
- Stores incoming box pixels into a ping-pong pair of line buffers at absolute x = base_x + delta_x.
- Streams the completed line to the display side at one pixel per clock, clearing each location to background as it is read.
- Sits between the graphic generator units and the video timing/scan-out stage.

Parameters:
- LINE_W, 1024, number of pixels per line buffer (addresses 0..LINE_W-1)
- PIX_W, 4, pixel/colour index width
- X_W, 12, x coordinate width

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous reset, active-high
- base_x  input  X_W  box origin x; sampled on the first accepted in_wr of each box
- in_wr  input  1  pixel write strobe from generator
- in_delta_x  input  X_W  pixel offset within box
- in_pix  input  PIX_W  pixel colour index
- in_done  input  1  last pixel of box (coincides with final in_wr)
- bg_color  input  PIX_W  value written back on clear-on-read
- scan_start  input  1  single-cycle request to swap banks and stream a line
- out_valid  output  1  streamed pixel valid
- out_x  output  X_W  streamed pixel x
- out_pix  output  PIX_W  streamed pixel value
- out_last  output  1  asserted with out_x == LINE_W-1
- box_busy  output  1  box write in progress (first in_wr through in_done)
- scan_busy  output  1  swap pending or streaming
- drop_cnt  output  16  count of dropped out-of-range writes, saturating

Behaviour:
- Reset (synchronous, active-high): out_valid=0, out_x=0, out_pix=0, out_last=0, box_busy=0, scan_busy=0, drop_cnt=0, wr_bank=0 (rd_bank=1), swap_pend=0, FSM=IDLE. RAM contents are not reset.
- Reset mid-box or mid-stream: abandon immediately; pixels already written stay in RAM; no clear pass is completed.
- Write side:
  - First in_wr with box_busy=0 latches base_x into base_reg and sets box_busy.
  - For that first write, the address uses base_x directly, not base_reg.
  - Address = base + in_delta_x as an X_W+1-bit sum.
  - If sum >= LINE_W: write is dropped and drop_cnt increments, saturating at 0xFFFF.
  - Otherwise write in_pix into bank wr_bank.
  - in_wr together with in_done clears box_busy the next cycle; the pixel is still written.
  - in_done without in_wr is ignored.
- Swap:
  - scan_start sets swap_pend; further scan_start while scan_busy is ignored.
  - Swap executes on the first cycle with swap_pend=1, box_busy=0, in_wr=0 and FSM=IDLE: wr_bank and rd_bank toggle, swap_pend clears, FSM goes to PRIME.
  - scan_busy = swap_pend OR FSM != IDLE.
- Scan FSM:
  - IDLE: outputs low; waits for swap.
  - PRIME: issue RAM read of address 0 on rd_bank (1-cycle read latency).
  - STREAM: each cycle out_valid=1, out_x=rd address of the previous cycle, out_pix=RAM data; concurrently write bg_color to that same address in rd_bank via that bank's write port, which the write side never uses.
  - out_last=1 at x=LINE_W-1; next cycle returns to IDLE with out_valid=0.
  - Latency from swap to first out_valid: 2 cycles. A line takes exactly LINE_W valid cycles with no gaps.
- Concurrency:
  - The write side may accept in_wr to wr_bank during STREAM; the banks are independent.
  - in_wr arriving in the swap cycle blocks the swap, so no write is lost or split.
- Each bank is a simple dual-port RAM: one write port, one synchronous read port. The write-port mux is selected by bank role.

Test Plan:
- Reset, then 10-pixel box: base_x=100, delta_x 0..9, pix=0x5, done on the 10th write; then scan_start -> after 2 cycles LINE_W valid outputs; x=100..109 give 0x5; stale/initial elsewhere; out_last at x=1023.
- Same line streamed again after second swap with no writes to that bank -> all pixels equal bg_color=0x0 (clear-on-read verified).
- Box base_x=1020, width 8 -> x=1020..1023 written, 4 writes dropped, drop_cnt=4, box_busy falls after done.
- scan_start asserted mid-box (write 3 of 10) -> swap deferred until cycle after in_done; scan_busy high throughout; all 10 pixels appear on the following scan.
- Box written into wr_bank during an active STREAM of rd_bank -> stream output unaffected; new box visible on next scan.
- Reset asserted at out_x=500 -> next cycle out_valid=0, scan_busy=0, drop_cnt=0, wr_bank=0.

Source files
------------

// File: rtl/line_sink.sv
// Ping-pong line buffer fed by a box generator pixel-write port.
// Streams one completed line per request, clearing to background on read.
module line_sink #(
  parameter int LINE_W = 1024,
  parameter int PIX_W  = 4,
  parameter int X_W    = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [X_W-1:0]   base_x,
  input  logic             in_wr,
  input  logic [X_W-1:0]   in_delta_x,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_done,
  input  logic [PIX_W-1:0] bg_color,
  input  logic             scan_start,
  output logic             out_valid,
  output logic [X_W-1:0]   out_x,
  output logic [PIX_W-1:0] out_pix,
  output logic             out_last,
  output logic             box_busy,
  output logic             scan_busy,
  output logic [15:0]      drop_cnt
);

  localparam int AW = $clog2(LINE_W);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM
  } state_t;

  state_t state;

  logic             wr_bank;
  logic             rd_bank;
  logic             swap_pend;
  logic [X_W-1:0]   base_reg;
  logic [X_W:0]     sum;
  logic             in_rng;
  logic             wr_ok;
  logic             swap;
  logic             rd_en;
  logic             clr_en;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic [AW-1:0]    clr_addr;
  logic [PIX_W-1:0] rdata;

  logic [PIX_W-1:0] mem0 [LINE_W];
  logic [PIX_W-1:0] mem1 [LINE_W];

  logic             we0;
  logic             we1;
  logic [AW-1:0]    a0;
  logic [AW-1:0]    a1;
  logic [PIX_W-1:0] d0;
  logic [PIX_W-1:0] d1;

  assign rd_bank = ~wr_bank;

  // First pixel of a box addresses from base_x before base_reg is loaded.
  assign sum = {1'b0, (box_busy ? base_reg : base_x)}
             + {1'b0, in_delta_x};
  assign in_rng  = sum < (X_W+1)'(LINE_W);
  assign wr_ok   = in_wr && in_rng;
  assign wr_addr = sum[AW-1:0];

  assign swap = swap_pend && !box_busy && !in_wr
             && (state == IDLE);
  assign scan_busy = swap_pend || (state != IDLE);

  assign rd_en = (state == PRIME)
              || ((state == STREAM) && !out_last);
  assign rd_addr = (state == PRIME) ? '0
                 : out_x[AW-1:0] + AW'(1);
  assign clr_en   = (state == STREAM);
  assign clr_addr = out_x[AW-1:0];

  // Each bank's single write port belongs to whichever role it holds.
  assign we0 = !reset && (wr_bank ? clr_en : wr_ok);
  assign a0  = wr_bank ? clr_addr : wr_addr;
  assign d0  = wr_bank ? bg_color : in_pix;
  assign we1 = !reset && (wr_bank ? wr_ok : clr_en);
  assign a1  = wr_bank ? wr_addr : clr_addr;
  assign d1  = wr_bank ? in_pix : bg_color;

  always_ff @(posedge clk) begin
    if (we0) mem0[a0] <= d0;
  end

  always_ff @(posedge clk) begin
    if (we1) mem1[a1] <= d1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= rd_bank ? mem1[rd_addr] : mem0[rd_addr];
    end else begin
      rdata <= '0;
    end
  end

  assign out_pix = rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      box_busy <= 1'b0;
      base_reg <= '0;
      drop_cnt <= '0;
    end else if (in_wr) begin
      if (!box_busy) base_reg <= base_x;
      box_busy <= !in_done;
      if (!in_rng && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_last  <= 1'b0;
      wr_bank   <= 1'b0;
      swap_pend <= 1'b0;
    end else begin
      if (swap) begin
        wr_bank   <= ~wr_bank;
        swap_pend <= 1'b0;
      end else if (scan_start && !scan_busy) begin
        swap_pend <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (swap) state <= PRIME;
        end
        PRIME: begin
          state     <= STREAM;
          out_valid <= 1'b1;
          out_x     <= '0;
          out_last  <= (LINE_W == 1);
        end
        STREAM: begin
          if (out_last) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_last  <= 1'b0;
          end else begin
            out_x    <= out_x + X_W'(1);
            out_last <= (out_x == X_W'(LINE_W - 2));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_sink.sv
// Randomized bench for line_sink against a per-bank array model.
// Boxes, swaps, clear-on-read, drops, deferral and reset abandonment.
module tb_line_sink;

  localparam int LW = 1024;
  localparam int PW = 4;
  localparam int XW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [XW-1:0] base_x;
  logic          in_wr;
  logic [XW-1:0] in_delta_x;
  logic [PW-1:0] in_pix;
  logic          in_done;
  logic [PW-1:0] bg_color;
  logic          scan_start;
  logic          out_valid;
  logic [XW-1:0] out_x;
  logic [PW-1:0] out_pix;
  logic          out_last;
  logic          box_busy;
  logic          scan_busy;
  logic [15:0]   drop_cnt;

  line_sink #(.LINE_W(LW), .PIX_W(PW), .X_W(XW)) dut (
    .clk(clk), .reset(reset), .base_x(base_x),
    .in_wr(in_wr), .in_delta_x(in_delta_x),
    .in_pix(in_pix), .in_done(in_done),
    .bg_color(bg_color), .scan_start(scan_start),
    .out_valid(out_valid), .out_x(out_x),
    .out_pix(out_pix), .out_last(out_last),
    .box_busy(box_busy), .scan_busy(scan_busy),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int bank [2][LW];
  int exp_line [LW];
  int wb;
  int mdrop;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_scan();
    scan_start = 1'b1;
    cyc();
    scan_start = 1'b0;
  endtask

  // Swap roles; the new read bank's content is the expected line
  // and becomes background once streamed.
  task automatic model_swap();
    wb ^= 1;
    for (int x = 0; x < LW; x++) begin
      exp_line[x] = bank[wb^1][x];
      bank[wb^1][x] = int'(bg_color);
    end
  endtask

  task automatic write_box(input int b, input int w,
                           input int col, input int scan_at);
    for (int i = 0; i < w; i++) begin
      base_x     = (i == 0) ? XW'(b) : XW'($urandom);
      in_wr      = 1'b1;
      in_delta_x = XW'(i);
      in_pix     = (col < 0) ? PW'($urandom) : PW'(col);
      in_done    = (i == w - 1);
      scan_start = (i == scan_at);
      if (b + i < LW) bank[wb][b+i] = int'(in_pix);
      else mdrop++;
      cyc();
      if (scan_at >= 0 && i >= scan_at) begin
        checks++;
        if (scan_busy !== 1'b1) begin
          errors++;
          $display("FAIL scan_busy_in_box i=%0d got %b exp 1",
                   i, scan_busy);
        end
      end
      if (i < w - 1) begin
        checks++;
        if (box_busy !== 1'b1) begin
          errors++;
          $display("FAIL box_busy_mid i=%0d got %b exp 1",
                   i, box_busy);
        end
      end
    end
    in_wr = 1'b0;
    in_done = 1'b0;
    scan_start = 1'b0;
    in_delta_x = '0;
    checks++;
    if (box_busy !== 1'b0) begin
      errors++;
      $display("FAIL box_busy_end got %b exp 0", box_busy);
    end
  endtask

  task automatic collect_line(input bit chk);
    int lat = 0;
    int bad = 0;
    while (out_valid !== 1'b1 && lat < 10) begin
      cyc();
      lat++;
    end
    checks++;
    if (out_valid !== 1'b1 || (chk && lat != 2)) begin
      errors++;
      $display("FAIL latency got %0d exp 2 valid=%b",
               lat, out_valid);
      if (out_valid !== 1'b1) return;
    end
    for (int x = 0; x < LW; x++) begin
      if (chk) begin
        checks++;
        if (out_valid !== 1'b1 || out_x !== XW'(x)
            || out_pix !== PW'(exp_line[x])
            || out_last !== (x == LW - 1)) begin
          errors++;
          if (bad < 8)
            $display("FAIL pixel x=%0d got v%b x%0d p%0h l%b exp p%0h",
                     x, out_valid, out_x, out_pix, out_last,
                     exp_line[x]);
          bad++;
        end
      end
      cyc();
    end
    checks++;
    if (out_valid !== 1'b0 || scan_busy !== 1'b0) begin
      errors++;
      $display("FAIL line_end got v%b busy%b exp 0 0",
               out_valid, scan_busy);
    end
  endtask

  task automatic scan_line(input bit chk);
    pulse_scan();
    model_swap();
    collect_line(chk);
  endtask

  task automatic check_drop(input string nm);
    checks++;
    if (drop_cnt !== 16'(mdrop)) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", nm, drop_cnt, mdrop);
    end
  endtask

  task automatic test_reset();
    base_x = '0; in_wr = 1'b0; in_delta_x = '0; in_pix = '0;
    in_done = 1'b0; bg_color = '0; scan_start = 1'b0;
    reset = 1'b1;
    cyc();
    cyc();
    checks += 7;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_valid got %b exp 0", out_valid);
    end
    if (out_x !== '0) begin
      errors++; $display("FAIL rst_x got %0d exp 0", out_x);
    end
    if (out_pix !== '0) begin
      errors++; $display("FAIL rst_pix got %0h exp 0", out_pix);
    end
    if (out_last !== 1'b0) begin
      errors++; $display("FAIL rst_last got %b exp 0", out_last);
    end
    if (box_busy !== 1'b0) begin
      errors++; $display("FAIL rst_box got %b exp 0", box_busy);
    end
    if (scan_busy !== 1'b0) begin
      errors++; $display("FAIL rst_scan got %b exp 0", scan_busy);
    end
    if (drop_cnt !== '0) begin
      errors++; $display("FAIL rst_drop got %0d exp 0", drop_cnt);
    end
    reset = 1'b0;
    wb = 0;
    mdrop = 0;
  endtask

  // RAM powers up undefined; two unchecked scans clear both banks.
  task automatic prime_banks();
    for (int k = 0; k < 2; k++)
      for (int x = 0; x < LW; x++) bank[k][x] = 0;
    scan_line(1'b0);
    scan_line(1'b0);
  endtask

  task automatic test_basic_box();
    bg_color = 4'h0;
    write_box(100, 10, 5, -1);
    scan_line(1'b1);
  endtask

  task automatic test_clear_on_read();
    scan_line(1'b1);
    scan_line(1'b1);
  endtask

  task automatic test_boundary();
    write_box(1020, 8, -1, -1);
    check_drop("drop_edge");
    write_box(4090, 10, -1, -1);
    check_drop("drop_wrap");
    scan_line(1'b1);
  endtask

  task automatic test_mid_box_scan();
    write_box(600, 10, 4'hA, 2);
    model_swap();
    collect_line(1'b1);
  endtask

  task automatic test_back_to_back();
    bg_color = PW'($urandom_range(1, 15));
    pulse_scan();
    model_swap();
    fork
      collect_line(1'b1);
      begin
        repeat (100) cyc();
        write_box($urandom_range(0, 1000), 24, -1, -1);
      end
    join
    scan_line(1'b1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      bg_color = PW'($urandom);
      for (int k = 0; k < 3; k++) begin
        write_box($urandom_range(0, 1100),
                  $urandom_range(1, 40), -1, -1);
        repeat ($urandom_range(0, 3)) cyc();
      end
      check_drop("drop_rand");
      scan_line(1'b1);
    end
  endtask

  task automatic test_reset_mid_stream();
    int n = 0;
    pulse_scan();
    model_swap();
    while (!(out_valid === 1'b1 && out_x === XW'(500))
           && n < 2000) begin
      cyc();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_x !== XW'(500)) begin
      errors++;
      $display("FAIL reach_x500 got %0d exp 500", out_x);
    end
    reset = 1'b1;
    cyc();
    checks += 4;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rr_valid got %b exp 0", out_valid);
    end
    if (scan_busy !== 1'b0) begin
      errors++; $display("FAIL rr_scan got %b exp 0", scan_busy);
    end
    if (drop_cnt !== '0) begin
      errors++; $display("FAIL rr_drop got %0d exp 0", drop_cnt);
    end
    if (out_pix !== '0) begin
      errors++; $display("FAIL rr_pix got %0h exp 0", out_pix);
    end
    reset = 1'b0;
    for (int x = 500; x < LW; x++) bank[wb^1][x] = exp_line[x];
    wb = 0;
    mdrop = 0;
    write_box(300, 20, -1, -1);
    scan_line(1'b1);
    scan_line(1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    prime_banks();
    test_basic_box();
    test_clear_on_read();
    test_boundary();
    test_mid_box_scan();
    test_back_to_back();
    test_random();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
